// File: rtl/gift_pkg.sv
// Shared constants, state type and round-constant step for the iterative GIFT controller.
package gift_pkg;

    localparam int GIFT64_ROUNDS  = 28;
    localparam int GIFT128_ROUNDS = 40;

    localparam int               RC_W     = 6;
    localparam logic [RC_W-1:0] RC_START = 6'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    // One step of the 6-bit round-constant LFSR: shift left, feed back c5^c4^1.
    function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/gift_iter_control_if.sv
// Host-side handshake and datapath-strobe bundle of the iterative GIFT controller.
interface gift_iter_control_if
    import gift_pkg::*;
#(
    parameter int CNT_W = 6
);
    logic             inExtKeyWr;
    logic             inExtDataWr;
    logic             inOutRd;
    logic             outIntKeyschRegExtWr;
    logic             outIntRoundRegExtWr;
    logic             outIntRoundRegWr;
    logic             outIntKeyschRegWr;
    logic             outIntDataOutRegWr;
    logic [RC_W-1:0]  outRoundConst;
    logic [CNT_W-1:0] outRoundIdx;
    logic             outBusy;
    logic             outReady;
    logic             outValid;

    modport master (
        output inExtKeyWr, inExtDataWr, inOutRd,
        input  outIntKeyschRegExtWr, outIntRoundRegExtWr, outIntRoundRegWr,
               outIntKeyschRegWr, outIntDataOutRegWr, outRoundConst,
               outRoundIdx, outBusy, outReady, outValid
    );

    modport slave (
        input  inExtKeyWr, inExtDataWr, inOutRd,
        output outIntKeyschRegExtWr, outIntRoundRegExtWr, outIntRoundRegWr,
               outIntKeyschRegWr, outIntDataOutRegWr, outRoundConst,
               outRoundIdx, outBusy, outReady, outValid
    );

endinterface

// File: rtl/gift_rc_lfsr.sv
// 6-bit round-constant LFSR: cleared by reset, seeded on load, advanced on step.
module gift_rc_lfsr
    import gift_pkg::*;
(
    input  logic            inClk,
    input  logic            inRst,
    input  logic            inLoad,
    input  logic            inStep,
    output logic [RC_W-1:0] outRc
);

    logic [RC_W-1:0] r_rc;

    // Load has priority over step so a start always begins at RC_START.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_rc <= '0;
        end else if (inLoad) begin
            r_rc <= RC_START;
        end else if (inStep) begin
            r_rc <= rc_next(r_rc);
        end
    end

    assign outRc = r_rc;

endmodule

// File: rtl/gift_iter_control.sv
// Sequencer for the folded GIFT datapath: load, ROUNDS round iterations, one output write.
module gift_iter_control
    import gift_pkg::*;
#(
    parameter int ROUNDS = GIFT64_ROUNDS,
    parameter int CNT_W  = 6
)(
    input  logic               inClk,
    input  logic               inRst,
    gift_iter_control_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             w_idle;
    logic             w_run;
    logic             w_final;
    logic             w_ready;
    logic             w_start;
    logic             w_last;
    logic [RC_W-1:0]  w_rc;

    assign w_idle  = (r_state == IDLE);
    assign w_run   = (r_state == RUN);
    assign w_final = (r_state == FINAL);
    assign w_ready = w_idle && (!r_valid || bus.inOutRd);
    assign w_start = bus.inExtDataWr && w_ready;
    assign w_last  = (r_cnt == CNT_W'(ROUNDS - 1));

    // Next-state selection for the IDLE -> RUN -> FINAL -> IDLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (w_last)  w_state_nxt = FINAL;
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, round counter and result-valid flag.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && w_start) begin
                r_cnt <= '0;
            end else if (w_run) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_final) begin
                r_valid <= 1'b1;
            end else if (w_idle && bus.inOutRd) begin
                r_valid <= 1'b0;
            end
        end
    end

    gift_rc_lfsr u_rc (
        .inClk  (inClk),
        .inRst  (inRst),
        .inLoad (w_idle && w_start),
        .inStep (w_run),
        .outRc  (w_rc)
    );

    // Write strobes are suppressed while reset is held, so an aborted run writes nothing.
    assign bus.outIntKeyschRegExtWr = w_idle && bus.inExtKeyWr && !inRst;
    assign bus.outIntRoundRegExtWr  = w_start && !inRst;
    assign bus.outIntRoundRegWr     = w_run && !inRst;
    assign bus.outIntKeyschRegWr    = w_run && !inRst;
    assign bus.outIntDataOutRegWr   = w_final && !inRst;
    assign bus.outRoundConst        = w_run ? w_rc : '0;
    assign bus.outRoundIdx          = w_run ? r_cnt : '0;
    assign bus.outBusy              = !w_idle;
    assign bus.outReady             = w_ready;
    assign bus.outValid             = r_valid;

endmodule

// File: tb/tb_gift_iter_control.sv
// Drives a 28-round and a 40-round controller with shared stimulus and checks both
// against a cycle-level reference model of the sequencing rules.
module tb_gift_iter_control;
    import gift_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic key  = 1'b0;
    logic data = 1'b0;
    logic rd   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gift_iter_control_if #(.CNT_W(6)) bus28 ();
    gift_iter_control_if #(.CNT_W(6)) bus40 ();

    assign bus28.inExtKeyWr  = key;
    assign bus28.inExtDataWr = data;
    assign bus28.inOutRd     = rd;
    assign bus40.inExtKeyWr  = key;
    assign bus40.inExtDataWr = data;
    assign bus40.inOutRd     = rd;

    gift_iter_control #(.ROUNDS(GIFT64_ROUNDS), .CNT_W(6)) dut28 (
        .inClk (clk),
        .inRst (rst),
        .bus   (bus28)
    );

    gift_iter_control #(.ROUNDS(GIFT128_ROUNDS), .CNT_W(6)) dut40 (
        .inClk (clk),
        .inRst (rst),
        .bus   (bus40)
    );

    logic [19:0] obs [2];
    assign obs[0] = {bus28.outIntKeyschRegExtWr, bus28.outIntRoundRegExtWr, bus28.outIntRoundRegWr,
                     bus28.outIntKeyschRegWr, bus28.outIntDataOutRegWr, bus28.outBusy,
                     bus28.outReady, bus28.outValid, bus28.outRoundConst, bus28.outRoundIdx};
    assign obs[1] = {bus40.outIntKeyschRegExtWr, bus40.outIntRoundRegExtWr, bus40.outIntRoundRegWr,
                     bus40.outIntKeyschRegWr, bus40.outIntDataOutRegWr, bus40.outBusy,
                     bus40.outReady, bus40.outValid, bus40.outRoundConst, bus40.outRoundIdx};

    // Reference model: phase -1 = idle, 0..R-1 = round index, R = output-write cycle.
    int mr [2] = '{28, 40};
    int mk [2] = '{-1, -1};
    bit mv [2] = '{1'b0, 1'b0};

    int early_rc [8]  = '{'h01, 'h03, 'h07, 'h0F, 'h1F, 'h3E, 'h3D, 'h3B};
    int tail40_rc [12] = '{'h17, 'h2E, 'h1C, 'h38, 'h31, 'h23, 'h06, 'h0D, 'h1B, 'h36, 'h2D, 'h1A};

    function automatic int rc_of(input int idx);
        logic [5:0] c = 6'h01;
        for (int i = 0; i < idx; i++) c = {c[4:0], ~(c[5] ^ c[4])};
        return int'(c);
    endfunction

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One clock: drive inputs, compare both DUTs against the model, then advance the model.
    task automatic cycle(input bit r, input bit k, input bit d, input bit o);
        @(negedge clk);
        rst = r; key = k; data = d; rd = o;
        #1;
        for (int i = 0; i < 2; i++) begin
            bit    idle, run, fin, ready, start;
            string p;
            idle  = (mk[i] < 0);
            run   = (mk[i] >= 0) && (mk[i] < mr[i]);
            fin   = (mk[i] == mr[i]);
            ready = idle && (!mv[i] || o);
            start = d && ready;
            p     = $sformatf("r%0d.", mr[i]);
            check({p, "keyExtWr"},   int'(obs[i][19]), int'(idle && k && !r));
            check({p, "roundExtWr"}, int'(obs[i][18]), int'(start && !r));
            check({p, "roundWr"},    int'(obs[i][17]), int'(run && !r));
            check({p, "keyschWr"},   int'(obs[i][16]), int'(run && !r));
            check({p, "dataOutWr"},  int'(obs[i][15]), int'(fin && !r));
            check({p, "busy"},       int'(obs[i][14]), int'(!idle));
            check({p, "ready"},      int'(obs[i][13]), int'(ready));
            check({p, "valid"},      int'(obs[i][12]), int'(mv[i]));
            check({p, "rc"},         int'(obs[i][11:6]), run ? rc_of(mk[i]) : 0);
            check({p, "idx"},        int'(obs[i][5:0]),  run ? mk[i] : 0);
            if (run && mk[i] < 8)
                check({p, "rcEarlyTab"}, int'(obs[i][11:6]), early_rc[mk[i]]);
            if (run && mr[i] == 40 && mk[i] >= 28)
                check({p, "rcTail40Tab"}, int'(obs[i][11:6]), tail40_rc[mk[i] - 28]);
            if (run && mr[i] == 28 && mk[i] == 27)
                check({p, "rcLast28"}, int'(obs[i][11:6]), 'h0B);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit start;
            start = (mk[i] < 0) && d && (!mv[i] || o);
            if (r) begin
                mk[i] = -1;
                mv[i] = 1'b0;
            end else if (mk[i] < 0) begin
                if (o) mv[i] = 1'b0;
                if (start) mk[i] = 0;
            end else if (mk[i] < mr[i]) begin
                mk[i] = (mk[i] == mr[i] - 1) ? mr[i] : mk[i] + 1;
            end else begin
                mk[i] = -1;
                mv[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int n;

        // Reset held with both write requests active.
        repeat (2) cycle(1, 1, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);

        // Key load, then start.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);

        // Write requests while busy at round index 10.
        n = 0;
        while (mk[0] != 10 && n < 60) begin cycle(0, 0, 0, 0); n++; end
        #1 check("reachIdx10", int'(bus28.outRoundIdx), 10);
        cycle(0, 1, 1, 0);

        n = 0;
        while ((mk[0] >= 0 || mk[1] >= 0) && n < 100) begin cycle(0, 0, 0, 0); n++; end
        #1 check("doneRun40", int'(bus40.outValid), 1);

        // Backpressure: start held while the result is unread, then start with acknowledge.
        repeat (5) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);

        // Reset mid-run at round index 12, then restart.
        n = 0;
        while (mk[0] != 12 && n < 60) begin cycle(0, 0, 0, 0); n++; end
        #1 check("reachIdx12", int'(bus28.outRoundIdx), 12);
        cycle(1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        n = 0;
        while ((mk[0] >= 0 || mk[1] >= 0) && n < 100) begin cycle(0, 0, 0, 0); n++; end
        #1 check("doneRestart40", int'(bus40.outValid), 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
